// File: rtl/sudoku_pkg.sv
// Shared constants and encodings for the Sudoku board checker.
package sudoku_pkg;

  localparam int unsigned DefaultN   = 9;
  localparam int unsigned DefaultBox = 3;
  localparam int unsigned DefaultVw  = 4;
  localparam int unsigned DefaultRw  = $clog2(DefaultN);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    GrpRow = 2'd0,
    GrpCol = 2'd1,
    GrpBox = 2'd2
  } group_e;

endpackage

// File: rtl/board_addr_gen.sv
// Group/cell counters for the board walk and the (group, cell) -> (row, col) mapping.
module board_addr_gen import sudoku_pkg::*; #(
  parameter int unsigned N   = DefaultN,
  parameter int unsigned BOX = DefaultBox,
  parameter int unsigned RW  = DefaultRw
) (
  input  logic          clka,
  input  logic          restart,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic [RW-1:0] gidx,
  output group_e        kind,
  output logic          first_cell,
  output logic          last_cell,
  output logic          last_group
);

  localparam int unsigned GW = $clog2(3 * N);

  logic [GW-1:0] grp_q;
  logic [RW-1:0] cell_q;

  assign first_cell = (cell_q == '0);
  assign last_cell  = (cell_q == RW'(N - 1));
  assign last_group = (grp_q == GW'(3 * N - 1));

  // Counters saturate on the final address so rd_row/rd_col hold once the walk ends.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      grp_q  <= '0;
      cell_q <= '0;
    end else if (clear) begin
      grp_q  <= '0;
      cell_q <= '0;
    end else if (advance && !(last_cell && last_group)) begin
      if (last_cell) begin
        cell_q <= '0;
        grp_q  <= grp_q + GW'(1);
      end else begin
        cell_q <= cell_q + RW'(1);
      end
    end
  end

  always_comb begin
    int unsigned g;
    int unsigned c;
    int unsigned b;
    g    = 32'(grp_q);
    c    = 32'(cell_q);
    b    = 0;
    kind = GrpRow;
    gidx = '0;
    row  = '0;
    col  = '0;
    if (g < N) begin
      kind = GrpRow;
      gidx = RW'(g);
      row  = RW'(g);
      col  = RW'(c);
    end else if (g < 2 * N) begin
      kind = GrpCol;
      gidx = RW'(g - N);
      row  = RW'(c);
      col  = RW'(g - N);
    end else begin
      b    = g - 2 * N;
      kind = GrpBox;
      gidx = RW'(b);
      row  = RW'((b / BOX) * BOX + c / BOX);
      col  = RW'((b % BOX) * BOX + c % BOX);
    end
  end

endmodule

// File: rtl/board_check_seq.sv
// Walks every row, column and box of the board RAM once per start and reports the result.
module board_check_seq import sudoku_pkg::*; #(
  parameter  int unsigned N   = DefaultN,
  parameter  int unsigned BOX = DefaultBox,
  parameter  int unsigned VW  = DefaultVw,
  localparam int unsigned RW  = $clog2(N)
) (
  input  logic          clka,
  input  logic          restart,
  input  logic          start,
  output logic          rd_en,
  output logic [RW-1:0] rd_row,
  output logic [RW-1:0] rd_col,
  input  logic [VW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          solved,
  output logic          full,
  output logic          conflict,
  output logic [1:0]    err_kind,
  output logic [RW-1:0] err_idx
);

  state_e        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic          full_q, full_d;
  logic          conflict_q, conflict_d;
  logic          solved_q, solved_d;
  logic [1:0]    err_kind_q, err_kind_d;
  logic [RW-1:0] err_idx_q, err_idx_d;

  // Group context travelling alongside the one-cycle read latency.
  logic          v_q, first_q;
  group_e        kind_q;
  logic [RW-1:0] gidx_q;

  logic          first_cell, last_cell, last_group;
  group_e        kind;
  logic [RW-1:0] gidx;
  logic          start_acc, process, hit;
  logic [N-1:0]  base, bit_oh;

  assign rd_en     = (state_q == StScan);
  assign busy      = (state_q == StScan) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign start_acc = (state_q == StIdle) && start;
  assign solved    = solved_q;
  assign full      = full_q;
  assign conflict  = conflict_q;
  assign err_kind  = err_kind_q;
  assign err_idx   = err_idx_q;

  board_addr_gen #(
    .N   (N),
    .BOX (BOX),
    .RW  (RW)
  ) u_addr_gen (
    .clka       (clka),
    .restart    (restart),
    .clear      (start_acc),
    .advance    (rd_en),
    .row        (rd_row),
    .col        (rd_col),
    .gidx       (gidx),
    .kind       (kind),
    .first_cell (first_cell),
    .last_cell  (last_cell),
    .last_group (last_group)
  );

  // Data arriving after an abort to DONE is ignored because process requires SCAN/DRAIN.
  always_comb begin
    process = v_q && ((state_q == StScan) || (state_q == StDrain));
    base    = first_q ? '0 : mask_q;
    bit_oh  = {{(N-1){1'b0}}, 1'b1} << (rd_data - VW'(1));
    hit     = process && (rd_data != '0) &&
              ((rd_data > VW'(N)) || ((base & bit_oh) != '0));
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    full_d     = full_q;
    conflict_d = conflict_q;
    solved_d   = solved_q;
    err_kind_d = err_kind_q;
    err_idx_d  = err_idx_q;

    if (process) begin
      mask_d = base;
      if (rd_data == '0) begin
        full_d = 1'b0;
      end else if (!hit) begin
        mask_d = base | bit_oh;
      end
      if (hit) begin
        conflict_d = 1'b1;
        if (!conflict_q) begin
          err_kind_d = kind_q;
          err_idx_d  = gidx_q;
        end
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StScan;
          mask_d     = '0;
          full_d     = 1'b1;
          conflict_d = 1'b0;
          solved_d   = 1'b0;
          err_kind_d = '0;
          err_idx_d  = '0;
        end
      end
      StScan: begin
        if (hit) begin
          state_d = StDone;
        end else if (last_cell && last_group) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if ((state_d == StDone) && (state_q != StDone)) begin
      solved_d = full_d & ~conflict_d;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      full_q     <= 1'b0;
      conflict_q <= 1'b0;
      solved_q   <= 1'b0;
      err_kind_q <= '0;
      err_idx_q  <= '0;
      v_q        <= 1'b0;
      first_q    <= 1'b0;
      kind_q     <= GrpRow;
      gidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      full_q     <= full_d;
      conflict_q <= conflict_d;
      solved_q   <= solved_d;
      err_kind_q <= err_kind_d;
      err_idx_q  <= err_idx_d;
      v_q        <= rd_en;
      first_q    <= first_cell;
      kind_q     <= kind;
      gidx_q     <= gidx;
    end
  end

endmodule

// File: tb/tb_board_check_seq.sv
// Scoreboard bench for board_check_seq on a 4x4 board with a one-cycle read RAM model.
module tb_board_check_seq;

  localparam int unsigned N   = 4;
  localparam int unsigned BOX = 2;
  localparam int unsigned VW  = 4;
  localparam int unsigned RW  = 2;

  logic          clka = 1'b0;
  logic          restart;
  logic          start;
  logic          rd_en;
  logic [RW-1:0] rd_row, rd_col;
  logic [VW-1:0] rd_data = '0;
  logic          busy, done, solved, full, conflict;
  logic [1:0]    err_kind;
  logic [RW-1:0] err_idx;

  logic [VW-1:0] mem [0:N-1][0:N-1];
  int            cyc   = 0;
  int            total = 0;
  int            bad   = 0;

  typedef struct {
    int edge_n;
    int solved;
    int full;
    int conflict;
    int kind;
    int idx;
    int nrd;
  } exp_t;

  exp_t sb[$];

  board_check_seq #(
    .N   (N),
    .BOX (BOX),
    .VW  (VW)
  ) dut (
    .clka     (clka),
    .restart  (restart),
    .start    (start),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .solved   (solved),
    .full     (full),
    .conflict (conflict),
    .err_kind (err_kind),
    .err_idx  (err_idx)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  always @(posedge clka) begin
    if (rd_en) rd_data <= mem[rd_row][rd_col];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts reads, pops an expectation on every done pulse.
  initial begin
    int   rd_cnt;
    logic prev_done;
    exp_t e;
    rd_cnt    = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clka);
      if (restart) begin
        rd_cnt    = 0;
        prev_done = 1'b0;
      end else begin
        if (rd_en) rd_cnt++;
        if (prev_done) check("done_width", int'(done), 0);
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("done_edge", cyc, e.edge_n);
            check("solved", int'(solved), e.solved);
            check("full", int'(full), e.full);
            check("conflict", int'(conflict), e.conflict);
            check("err_kind", int'(err_kind), e.kind);
            check("err_idx", int'(err_idx), e.idx);
            check("rd_count", rd_cnt, e.nrd);
          end
          rd_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic load(input logic [63:0] b);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mem[r][c] = b[63 - (r * 4 + c) * 4 -: 4];
      end
    end
  endtask

  task automatic do_start(output int s);
    @(negedge clka);
    #1 start = 1'b1;
    @(negedge clka);
    #1 start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0 && !busy && !done) break;
      @(negedge clka);
      #1;
    end
    check("pending_after_wait", sb.size(), 0);
  endtask

  task automatic run(input logic [63:0] b, input int s_exp, input int f_exp, input int c_exp,
                     input int k_exp, input int i_exp, input int lat, input int nrd);
    int   s;
    exp_t e;
    load(b);
    do_start(s);
    e = '{edge_n: s + lat, solved: s_exp, full: f_exp, conflict: c_exp,
          kind: k_exp, idx: i_exp, nrd: nrd};
    sb.push_back(e);
    wait_idle(200);
  endtask

  localparam logic [63:0] Valid   = 64'h1234_3412_2143_4321;
  localparam logic [63:0] Empty23 = 64'h1234_3412_2140_4321;
  localparam logic [63:0] RowDup  = 64'h1234_3413_2143_4321;
  localparam logic [63:0] ColDup  = 64'h1243_3412_2143_4321;
  localparam logic [63:0] BoxDup  = 64'h0000_0000_0010_0001;
  localparam logic [63:0] BadVal  = 64'h5234_3412_2143_4321;

  initial begin
    int   s;
    exp_t e;
    restart = 1'b1;
    start   = 1'b0;
    load(Valid);
    #12;
    check("reset_outputs", int'({rd_en, busy, done, solved, full, conflict, err_kind, err_idx,
                                 rd_row, rd_col}), 0);
    @(negedge clka);
    #1 restart = 1'b0;

    run(Valid, 1, 1, 0, 0, 0, 49, 48);
    repeat (3) @(negedge clka);
    check("solved_hold", int'(solved), 1);

    run(Empty23, 0, 0, 0, 0, 0, 49, 48);
    run(RowDup,  0, 1, 1, 0, 1,  9,  9);
    run(ColDup,  0, 1, 1, 1, 2, 28, 28);
    run(BoxDup,  0, 0, 1, 2, 3, 49, 48);
    run(BadVal,  0, 1, 1, 0, 0,  2,  2);

    // Asynchronous restart in the middle of a scan.
    load(Valid);
    do_start(s);
    for (int i = 0; i < 40; i++) begin
      if (cyc == s + 20) break;
      @(negedge clka);
      #1;
    end
    check("busy_in_scan", int'(busy), 1);
    check("full_in_scan", int'(full), 1);
    restart = 1'b1;
    #1;
    check("restart_outputs", int'({rd_en, busy, done, solved, full, conflict, err_kind, err_idx}),
          0);
    @(negedge clka);
    #1 restart = 1'b0;
    run(Valid, 1, 1, 0, 0, 0, 49, 48);

    // Start while busy and in DONE is ignored; start in the following idle cycle is taken.
    load(Valid);
    do_start(s);
    e = '{edge_n: s + 49, solved: 1, full: 1, conflict: 0, kind: 0, idx: 0, nrd: 48};
    sb.push_back(e);
    repeat (10) @(negedge clka);
    #1 start = 1'b1;
    @(negedge clka);
    #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clka);
      #1;
      if (done) break;
    end
    check("done_seen", int'(done), 1);
    start = 1'b1;
    e = '{edge_n: cyc + 2 + 49, solved: 1, full: 1, conflict: 0, kind: 0, idx: 0, nrd: 48};
    sb.push_back(e);
    @(negedge clka);
    #1;
    @(negedge clka);
    #1 start = 1'b0;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
